// File: rtl/csa_acc_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator.
package csa_acc_pkg;

    localparam int unsigned DEF_WIDTH = 2048;
    localparam int unsigned DEF_CHUNK = 64;
    localparam int unsigned DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        RESOLVE = 2'd1,
        DONE    = 2'd2
    } state_t;

    function automatic int unsigned chunk_count(input int unsigned width, input int unsigned chunk);
        return width / chunk;
    endfunction

    // Chunk index width; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/csa_accumulator_cpa_chunk.sv
// One CHUNK-bit slice of the carry-propagate adder, shared across all chunks.
module cpa_chunk #(
    parameter int unsigned CHUNK = 64
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/csa_accumulator.sv
// Streaming multi-operand accumulator: carry-save fold per operand, then a
// chunked carry-propagate resolve into a valid/ready result.
module csa_accumulator
    import csa_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_count
);

    localparam int unsigned   NCHUNK = chunk_count(WIDTH, CHUNK);
    localparam int unsigned   KW     = idx_width(NCHUNK);
    localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

    generate
        if (WIDTH % CHUNK != 0) begin : g_bad_chunk
            $error("csa_accumulator: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t state, next_state;

    logic [WIDTH-1:0] acc_s;
    // Carry word stored without its MSB: the carry out of bit WIDTH-1 wraps away.
    logic [WIDTH-2:0] acc_c;
    logic [WIDTH-1:0] cs;
    logic [WIDTH-2:0] maj;
    logic [CNT_W-1:0] count;
    logic [KW-1:0]    k;
    logic             carry_reg;

    logic [NCHUNK-1:0][CHUNK-1:0] s_chunks;
    logic [NCHUNK-1:0][CHUNK-1:0] cs_chunks;
    logic [NCHUNK-1:0][CHUNK-1:0] res_chunks;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;

    logic accept;
    logic clear;

    assign cs        = {acc_c, 1'b0};
    assign maj       = (acc_s[WIDTH-2:0] & cs[WIDTH-2:0])
                     | (acc_s[WIDTH-2:0] & in_data[WIDTH-2:0])
                     | (cs[WIDTH-2:0]    & in_data[WIDTH-2:0]);
    assign s_chunks  = acc_s;
    assign cs_chunks = cs;
    assign chunk_a   = s_chunks[k];
    assign chunk_b   = cs_chunks[k];

    cpa_chunk #(
        .CHUNK(CHUNK)
    ) u_cpa (
        .a   (chunk_a),
        .b   (chunk_b),
        .cin (carry_reg),
        .sum (chunk_sum),
        .cout(chunk_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        clear      = 1'b0;
        case (state)
            ACCUM: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid && in_last) begin
                    next_state = RESOLVE;
                end
            end
            RESOLVE: begin
                if (k == K_LAST) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    clear      = 1'b1;
                    next_state = ACCUM;
                end
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_s      <= '0;
            acc_c      <= '0;
            count      <= '0;
            k          <= '0;
            carry_reg  <= 1'b0;
            res_chunks <= '0;
        end else if (accept) begin
            acc_s <= acc_s ^ cs ^ in_data;
            acc_c <= maj;
            if (count != '1) begin
                count <= count + 1'b1;
            end
            if (in_last) begin
                k         <= '0;
                carry_reg <= 1'b0;
            end
        end else if (state == RESOLVE) begin
            // acc_s/acc_c are frozen here, so each chunk sees the post-fold pair.
            res_chunks[k] <= chunk_sum;
            carry_reg     <= chunk_cout;
            if (k != K_LAST) begin
                k <= k + 1'b1;
            end
        end else if (clear) begin
            acc_s <= '0;
            acc_c <= '0;
            count <= '0;
            k     <= '0;
        end
    end

    assign out_data  = res_chunks;
    assign out_count = count;

endmodule

// File: tb/tb_csa_accumulator.sv
// Directed self-checking bench for csa_accumulator at WIDTH=16, CHUNK=4, CNT_W=4.
module tb_csa_accumulator;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_count;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    csa_accumulator #(
        .WIDTH(16),
        .CHUNK(4),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] x, input logic last);
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        tick();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 20 && !out_valid; i++) tick();
        chk(tag, {15'b0, out_valid}, 16'h0001);
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic finish_sum(input string tag, input logic [15:0] exp_data, input logic [3:0] exp_cnt);
        wait_valid({tag, "_valid"});
        chk({tag, "_data"}, out_data, exp_data);
        chk({tag, "_count"}, {12'b0, out_count}, {12'b0, exp_cnt});
        take();
        chk({tag, "_in_ready_after"}, {15'b0, in_ready}, 16'h0001);
        chk({tag, "_out_valid_after"}, {15'b0, out_valid}, 16'h0000);
    endtask

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        idle_in();

        // 1: reset
        tick();
        tick();
        chk("rst_hold_out_valid", {15'b0, out_valid}, 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("rst_in_ready", {15'b0, in_ready}, 16'h0001);
        chk("rst_out_valid", {15'b0, out_valid}, 16'h0000);
        chk("rst_out_data", out_data, 16'h0000);
        chk("rst_out_count", {12'b0, out_count}, 16'h0000);

        // 2: single operand, exact latency of NCHUNK=4 cycles
        send(16'h1234, 1'b1);
        idle_in();
        chk("single_lat0", {15'b0, out_valid}, 16'h0000);
        chk("single_in_ready_resolve", {15'b0, in_ready}, 16'h0000);
        tick();
        chk("single_lat1", {15'b0, out_valid}, 16'h0000);
        tick();
        chk("single_lat2", {15'b0, out_valid}, 16'h0000);
        tick();
        chk("single_lat3", {15'b0, out_valid}, 16'h0000);
        tick();
        chk("single_lat4", {15'b0, out_valid}, 16'h0001);
        finish_sum("single", 16'h1234, 4'd1);

        // 3: back-to-back, carry ripples through every chunk boundary
        send(16'h00FF, 1'b0);
        send(16'h0001, 1'b0);
        send(16'h0F00, 1'b1);
        idle_in();
        tick();
        chk("ripple_chunk0", out_data, 16'h1230);
        tick();
        chk("ripple_chunk1", out_data, 16'h1200);
        tick();
        chk("ripple_chunk2", out_data, 16'h1000);
        tick();
        finish_sum("ripple", 16'h1000, 4'd3);

        // 4: modular wrap, then counter saturation
        send(16'hFFFF, 1'b0);
        send(16'h0002, 1'b1);
        idle_in();
        finish_sum("wrap", 16'h0001, 4'd2);

        for (int i = 0; i < 20; i++) send(16'h0001, (i == 19));
        idle_in();
        finish_sum("sat", 16'h0014, 4'hF);

        // 5: backpressure in DONE, input ignored while not ready
        send(16'h00A5, 1'b1);
        idle_in();
        wait_valid("bp_valid");
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", {15'b0, out_valid}, 16'h0001);
            chk("bp_out_data", out_data, 16'h00A5);
            chk("bp_in_ready", {15'b0, in_ready}, 16'h0000);
        end
        idle_in();
        take();
        chk("bp_in_ready_after", {15'b0, in_ready}, 16'h0001);
        chk("bp_out_valid_after", {15'b0, out_valid}, 16'h0000);
        chk("bp_data_held", out_data, 16'h00A5);
        chk("bp_count_cleared", {12'b0, out_count}, 16'h0000);
        send(16'h0007, 1'b1);
        idle_in();
        finish_sum("after_bp", 16'h0007, 4'd1);

        // 6: reset during RESOLVE chunk 2 aborts the sum
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b1);
        idle_in();
        tick();
        tick();
        chk("abort_partial", out_data, 16'h0033);
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {15'b0, in_ready}, 16'h0001);
        chk("abort_out_valid", {15'b0, out_valid}, 16'h0000);
        chk("abort_out_data", out_data, 16'h0000);
        chk("abort_out_count", {12'b0, out_count}, 16'h0000);
        tick();
        tick();
        chk("abort_hold_valid", {15'b0, out_valid}, 16'h0000);
        rst_n = 1'b1;
        tick();
        send(16'h0005, 1'b1);
        idle_in();
        finish_sum("post_abort", 16'h0005, 4'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
